// File: rtl/mem_port_arbiter.sv
// Registered grant FSM sharing one axi_interface port between the I-cache and D-cache miss paths.
// Optional round-robin arbitration on contention is enabled with `define MEM_ARB_RR_EN.
module mem_port_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_strobe,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    input  logic          d_strobe,
    input  logic          d_rw,
    input  logic [AW-1:0] d_addr,
    input  logic [1:0]    d_size,
    input  logic [3:0]    d_sel,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    input  logic          flush,
    output logic [AW-1:0] mem_a,
    output logic          mem_access,
    output logic          mem_write,
    output logic [1:0]    mem_size,
    output logic [3:0]    mem_sel,
    output logic [DW-1:0] mem_st_data,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_data,
    output logic          grant_d
);

    typedef enum logic [1:0] {StIdle, StGntI, StGntD, StCancel} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [1:0]      size_q, size_d;
    logic [3:0]      sel_q, sel_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            d_req;
    logic            pick_d;

    // kseg0/kseg1 both alias the low 512 MiB of physical space.
    function automatic logic [AW-1:0] phys_map(input logic [AW-1:0] va);
        if (va[AW-1 -: 3] == 3'b100 || va[AW-1 -: 3] == 3'b101) begin
            return {3'b000, va[AW-4:0]};
        end
        return va;
    endfunction

    assign d_req = d_strobe & ~flush;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;  // 1 = D side was granted last

    // On contention the side that was not served last wins.
    assign pick_d = d_req & (~i_strobe | ~last_grant_q);

    always_comb begin
        last_grant_d = last_grant_q;
        if (mem_ready) begin
            if (state_q == StGntI) begin
                last_grant_d = 1'b0;
            end else if (state_q == StGntD || state_q == StCancel) begin
                last_grant_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        size_d  = size_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (pick_d) begin
                    state_d = StGntD;
                    addr_d  = phys_map(d_addr);
                    rw_d    = d_rw;
                    size_d  = d_size;
                    sel_d   = d_sel;
                    wdata_d = d_wdata;
                end else if (i_strobe) begin
                    state_d = StGntI;
                    addr_d  = phys_map(i_addr);
                    rw_d    = 1'b0;
                    size_d  = 2'd2;
                    sel_d   = 4'b1111;
                    wdata_d = '0;
                end
            end
            StGntI: begin
                if (mem_ready) state_d = StIdle;
            end
            StGntD: begin
                // A completing access wins over a coincident flush.
                if (mem_ready) begin
                    state_d = StIdle;
                end else if (flush) begin
                    state_d = StCancel;
                end
            end
            StCancel: begin
                if (mem_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            size_q  <= 2'd0;
            sel_q   <= 4'd0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_access  = (state_q != StIdle);
    assign mem_a       = addr_q;
    assign mem_write   = rw_q;
    assign mem_size    = size_q;
    assign mem_sel     = sel_q;
    assign mem_st_data = wdata_q;

    assign i_ready = (state_q == StGntI) & mem_ready;
    assign d_ready = (state_q == StGntD) & mem_ready;
    assign i_rdata = mem_data;
    assign d_rdata = mem_data;
    assign grant_d = (state_q == StGntD) | (state_q == StCancel);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected completions, a negedge
// monitor pops and checks them whenever i_ready or d_ready fires.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_strobe;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_strobe;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        flush;
    logic [31:0] mem_a;
    logic        mem_access;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [31:0] mem_st_data;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        grant_d;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        side;  // 1 = D
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  sel;
    } exp_t;

    exp_t exp_q[$];

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_strobe   (i_strobe),
        .i_addr     (i_addr),
        .i_ready    (i_ready),
        .i_rdata    (i_rdata),
        .d_strobe   (d_strobe),
        .d_rw       (d_rw),
        .d_addr     (d_addr),
        .d_size     (d_size),
        .d_sel      (d_sel),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .flush      (flush),
        .mem_a      (mem_a),
        .mem_access (mem_access),
        .mem_write  (mem_write),
        .mem_size   (mem_size),
        .mem_sel    (mem_sel),
        .mem_st_data(mem_st_data),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .grant_d    (grant_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (i_ready || d_ready) begin
            chk1("one_ready_at_a_time", i_ready & d_ready, 1'b0);
            if (exp_q.size() == 0) begin
                chk1("unexpected_ready", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk1("ready_side", d_ready, e.side);
                chk("rdata", e.side ? d_rdata : i_rdata, e.data);
                chk("done_mem_a", mem_a, e.addr);
                chk1("done_mem_write", mem_write, e.wr);
                chk("done_mem_size", {30'b0, mem_size}, {30'b0, e.size});
                chk("done_mem_sel", {28'b0, mem_sel}, {28'b0, e.sel});
                chk("done_mem_st_data", mem_st_data, e.wdata);
            end
        end
    end

    task automatic push_exp(input logic side, input logic [31:0] rd, input logic [31:0] pa,
                            input logic wr, input logic [1:0] sz, input logic [3:0] sl,
                            input logic [31:0] wd);
        exp_t e;
        e.side = side; e.data = rd; e.addr = pa; e.wr = wr;
        e.size = sz; e.sel = sl; e.wdata = wd;
        exp_q.push_back(e);
    endtask

    // Assumes the winner's strobe is already high; grants, waits lat cycles, completes.
    task automatic grant_phase(input logic side, input logic [31:0] pa, input logic wr,
                               input logic [1:0] sz, input logic [3:0] sl,
                               input logic [31:0] wd, input logic [31:0] rd, input int lat,
                               input logic flush_at_ready);
        @(posedge clk); #1;
        chk1("grant_side", grant_d, side);
        for (int c = 0; c < lat; c++) begin
            chk1("wait_mem_access", mem_access, 1'b1);
            chk("wait_mem_a", mem_a, pa);
            chk1("wait_mem_write", mem_write, wr);
            chk("wait_mem_size", {30'b0, mem_size}, {30'b0, sz});
            chk("wait_mem_sel", {28'b0, mem_sel}, {28'b0, sl});
            chk("wait_mem_st_data", mem_st_data, wd);
            chk1("wait_no_i_ready", i_ready, 1'b0);
            chk1("wait_no_d_ready", d_ready, 1'b0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        mem_data  = rd;
        flush     = flush_at_ready;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_data  = 32'h0;
        flush     = 1'b0;
        if (side) d_strobe = 1'b0;
        else      i_strobe = 1'b0;
        chk1("idle_after_done", mem_access, 1'b0);
    endtask

    task automatic i_access(input logic [31:0] va, input logic [31:0] pa, input logic [31:0] rd,
                            input int lat);
        push_exp(1'b0, rd, pa, 1'b0, 2'd2, 4'hF, 32'h0);
        i_strobe = 1'b1;
        i_addr   = va;
        grant_phase(1'b0, pa, 1'b0, 2'd2, 4'hF, 32'h0, rd, lat, 1'b0);
    endtask

    task automatic d_access(input logic wr, input logic [31:0] va, input logic [31:0] pa,
                            input logic [1:0] sz, input logic [3:0] sl, input logic [31:0] wd,
                            input logic [31:0] rd, input int lat, input logic fl);
        push_exp(1'b1, rd, pa, wr, sz, sl, wd);
        d_strobe = 1'b1;
        d_rw     = wr;
        d_addr   = va;
        d_size   = sz;
        d_sel    = sl;
        d_wdata  = wd;
        grant_phase(1'b1, pa, wr, sz, sl, wd, rd, lat, fl);
    endtask

    initial begin
        rst = 1'b1;
        i_strobe = 1'b0; i_addr = 32'h0;
        d_strobe = 1'b0; d_rw = 1'b0; d_addr = 32'h0; d_size = 2'd0; d_sel = 4'h0;
        d_wdata = 32'h0; flush = 1'b0; mem_ready = 1'b0; mem_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_mem_access", mem_access, 1'b0);
        chk1("reset_mem_write", mem_write, 1'b0);
        chk1("reset_grant_d", grant_d, 1'b0);
        chk1("reset_i_ready", i_ready, 1'b0);
        chk1("reset_d_ready", d_ready, 1'b0);
        chk("reset_mem_a", mem_a, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("idle_no_access", mem_access, 1'b0);

        // I-only kseg1 read, 3 wait cycles
        i_access(32'hBFC0_0000, 32'h1FC0_0000, 32'h3C08_BFAF, 3);
        // D byte write to kseg0, 5 wait cycles
        d_access(1'b1, 32'h9FAF_0004, 32'h1FAF_0004, 2'd0, 4'b0010, 32'h0000_AB00,
                 32'h0, 5, 1'b0);
        // I kseg0 read, zero wait
        i_access(32'h8000_0010, 32'h0000_0010, 32'h1111_2222, 0);
        // D word read, unmapped useg address
        d_access(1'b0, 32'h0000_1000, 32'h0000_1000, 2'd2, 4'hF, 32'h0,
                 32'h1234_5678, 1, 1'b0);

        // Contention; last completion was D
`ifdef MEM_ARB_RR_EN
        push_exp(1'b0, 32'hAAAA_0001, 32'h1FC0_0040, 1'b0, 2'd2, 4'hF, 32'h0);
        push_exp(1'b1, 32'hBBBB_0002, 32'h0000_2000, 1'b0, 2'd2, 4'hF, 32'h0);
`else
        push_exp(1'b1, 32'hBBBB_0002, 32'h0000_2000, 1'b0, 2'd2, 4'hF, 32'h0);
        push_exp(1'b0, 32'hAAAA_0001, 32'h1FC0_0040, 1'b0, 2'd2, 4'hF, 32'h0);
`endif
        i_strobe = 1'b1; i_addr = 32'hBFC0_0040;
        d_strobe = 1'b1; d_rw = 1'b0; d_addr = 32'h8000_2000; d_size = 2'd2; d_sel = 4'hF;
        d_wdata = 32'h0;
`ifdef MEM_ARB_RR_EN
        grant_phase(1'b0, 32'h1FC0_0040, 1'b0, 2'd2, 4'hF, 32'h0, 32'hAAAA_0001, 2, 1'b0);
        grant_phase(1'b1, 32'h0000_2000, 1'b0, 2'd2, 4'hF, 32'h0, 32'hBBBB_0002, 2, 1'b0);
`else
        grant_phase(1'b1, 32'h0000_2000, 1'b0, 2'd2, 4'hF, 32'h0, 32'hBBBB_0002, 2, 1'b0);
        grant_phase(1'b0, 32'h1FC0_0040, 1'b0, 2'd2, 4'hF, 32'h0, 32'hAAAA_0001, 2, 1'b0);
`endif

        // Flush mid-access: D read cancelled, pending I request served next
        push_exp(1'b0, 32'h5555_6666, 32'h1FC0_0100, 1'b0, 2'd2, 4'hF, 32'h0);
        d_strobe = 1'b1; d_rw = 1'b0; d_addr = 32'h0000_1000; d_size = 2'd2; d_sel = 4'hF;
        d_wdata = 32'h0;
        @(posedge clk); #1;
        chk1("flush_grant_d", grant_d, 1'b1);
        i_strobe = 1'b1; i_addr = 32'h9FC0_0100;
        @(posedge clk); #1;
        flush = 1'b1; d_strobe = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        chk1("cancel_mem_access", mem_access, 1'b1);
        chk1("cancel_grant_d", grant_d, 1'b1);
        chk("cancel_mem_a", mem_a, 32'h0000_1000);
        @(posedge clk); #1;
        chk1("cancel_hold_access", mem_access, 1'b1);
        mem_ready = 1'b1; mem_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_data = 32'h0;
        chk1("cancel_to_idle", mem_access, 1'b0);
        chk1("cancel_grant_released", grant_d, 1'b0);
        grant_phase(1'b0, 32'h1FC0_0100, 1'b0, 2'd2, 4'hF, 32'h0, 32'h5555_6666, 1, 1'b0);

        // Flush coincident with mem_ready completes normally
        d_access(1'b0, 32'h8000_2000, 32'h0000_2000, 2'd1, 4'b1100, 32'h0,
                 32'hCAFE_F00D, 2, 1'b1);
        // kseg2 address is not remapped
        i_access(32'hC000_1234, 32'hC000_1234, 32'h0BAD_CAFE, 1);
        // D half write to kseg1, write data latched
        d_access(1'b1, 32'hA000_0102, 32'h0000_0102, 2'd1, 4'b1100, 32'h1234_0000,
                 32'h0, 2, 1'b0);

        // Async reset mid GNT_I with mem_ready high: no ready pulse
        i_strobe = 1'b1; i_addr = 32'hBFC0_0200;
        @(posedge clk); #1;
        chk1("pre_reset_access", mem_access, 1'b1);
        #1;
        rst = 1'b1; mem_ready = 1'b1; mem_data = 32'h7777_7777;
        #1;
        chk1("async_reset_access", mem_access, 1'b0);
        chk1("async_reset_i_ready", i_ready, 1'b0);
        chk1("async_reset_grant_d", grant_d, 1'b0);
        chk("async_reset_mem_a", mem_a, 32'h0);
        i_strobe = 1'b0; mem_ready = 1'b0; mem_data = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk1("post_reset_idle", mem_access, 1'b0);

        // Normal service after reset
        i_access(32'h0040_0000, 32'h0040_0000, 32'h2408_0001, 1);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
